ps2_kbd_rx: RTL and testbench
=============================

PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 Parameter FILTER_LEN, default 8, is the number of consecutive equal synchronized samples needed to accept a new ps2_clk level.
REQ-002 Parameter TIMEOUT_CYCLES, default 25000, is the number of clk cycles without a filtered falling edge after which a partial frame is aborted (1 ms at 25 MHz).
REQ-003 clk  input  1  system clock; the only clock; all state SHALL be in this domain.
REQ-004 reset_n_i  input  1  asynchronous, active-low reset.
REQ-005 ps2_clk_i  input  1  raw PS/2 keyboard clock, asynchronous.
REQ-006 ps2_data_i  input  1  raw PS/2 keyboard data, asynchronous.
REQ-007 code_o  output  8  last correctly received scancode byte.
REQ-008 strobe_o  output  1  one-cycle pulse; code_o is valid and newly updated.
REQ-009 err_o  output  1  one-cycle pulse; a frame failed framing or parity, or timed out.

Function
REQ-010 Each of ps2_clk_i and ps2_data_i SHALL pass a 2-flop synchronizer before any other use.
REQ-011 The filtered clock SHALL change level only after FILTER_LEN consecutive synchronized samples at the new level; shorter pulses SHALL be ignored.
REQ-012 A falling edge of the filtered clock SHALL produce a one-cycle sample event; data SHALL be taken from the synchronized ps2_data on that cycle.
REQ-013 The FSM SHALL have states IDLE, RECV, CHECK.
REQ-014 In IDLE, a sample event with data=0 (start bit) SHALL enter RECV with bit counter = 1; a sample event with data=1 SHALL be ignored.
REQ-015 In RECV, each sample event SHALL shift data into an 11-bit frame register (bit 0 = start, bits 1-8 = data LSB first, bit 9 = parity, bit 10 = stop) and increment the counter; the event that stores bit 10 SHALL move to CHECK.
REQ-016 CHECK SHALL last exactly one cycle and then return to IDLE.
REQ-017 In CHECK, the frame is good if start=0, stop=1 and XOR of data and parity bits = 1 (odd parity).
REQ-018 Good frame: strobe_o=1 and code_o=data bits, both in the cycle after the stop-bit sample event.
REQ-019 Bad frame: err_o=1 in the same cycle; code_o SHALL keep its previous value.
REQ-020 strobe_o and err_o SHALL never be asserted together.
REQ-021 In RECV, a timeout counter SHALL be cleared on every sample event and increment otherwise; on reaching TIMEOUT_CYCLES it SHALL pulse err_o once, discard the partial frame and return to IDLE.
REQ-022 The timeout counter SHALL be held at 0 in IDLE and CHECK; its width SHALL be $clog2(TIMEOUT_CYCLES+1).
REQ-023 Sample events arriving during CHECK SHALL be ignored; the next frame starts from IDLE.
REQ-024 Frames SHALL be accepted back to back with no minimum idle time beyond one CHECK cycle.

Reset
REQ-025 While reset_n_i=0: state=IDLE, counters=0, code_o=8'h00, strobe_o=0, err_o=0, synchronizer and filter state=1 (bus idle high).
REQ-026 Reset asserted mid-frame SHALL discard the partial frame and emit no strobe_o or err_o for it.
REQ-027 Reset release SHALL be synchronized internally so that all flops leave reset on the same clk edge.

Structure
REQ-028 Package ps2_pkg SHALL hold the FSM state enum, the frame length constant (11) and the frame bit-position constants.
REQ-029 Synchronization, filtering and falling-edge detection SHALL live in one sub-module ps2_filter, instantiated once for clock and data; edge detect SHALL be used only on the clock instance.

Verification
REQ-030 Frame 0x1C (bits 0,0,0,1,1,1,0,0,0,0,1; parity 0) at 12.5 kHz PS/2 clock -> one strobe_o, code_o=8'h1C, err_o never asserted.
REQ-031 Frame 0x1C with parity bit forced to 1 -> one err_o pulse, no strobe_o, code_o unchanged (8'h00 after reset).
REQ-032 Back-to-back frames 0xF0 (parity 1) then 0x1C -> two strobe_o pulses, code_o 8'hF0 then 8'h1C.
REQ-033 Start bit plus 4 data bits, then the clock stops -> exactly one err_o, TIMEOUT_CYCLES cycles after the last sample event; a following good 0x1C frame is received correctly.
REQ-034 3-cycle low glitch on ps2_clk_i during idle and mid-frame (FILTER_LEN=8) -> no extra bit sampled; 0x1C is still received correctly.
REQ-035 reset_n_i pulsed low after 6 bits of a frame -> no strobe_o and no err_o; outputs are at reset values; the next 0x1C frame produces strobe_o.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: FSM states, frame
// layout and the frame validity check.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_CHECK = 2'd2
    } ps2_state_e;

    // A frame is start, eight data bits LSB first, odd parity, stop.
    localparam int FRAME_LEN  = 11;
    localparam int START_POS  = 0;
    localparam int DATA_LSB   = 1;
    localparam int DATA_MSB   = 8;
    localparam int PARITY_POS = 9;
    localparam int STOP_POS   = 10;

    // Odd parity holds when data plus parity carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

    // Start low, stop high, odd parity over data and parity bits.
    function automatic logic frame_good(input logic [FRAME_LEN-1:0] frame);
        return (frame[START_POS] == 1'b0) &&
               (frame[STOP_POS] == 1'b1) &&
               odd_parity_ok(frame[PARITY_POS:DATA_LSB]);
    endfunction

endpackage

// File: rtl/ps2_filter.sv
// Two-flop synchronizer followed by a level filter that accepts a new level
// only after FILTER_LEN consecutive equal samples, with optional falling
// edge pulse on the filtered level.
module ps2_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter bit EDGE_EN    = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic sync,
    output logic level,
    output logic fall
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic [1:0]       sync_r;
    logic             level_r;
    logic             fall_r;
    logic [CNT_W-1:0] cnt_r;

    // Bring the asynchronous line into the clk domain; bus idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], raw};
        end
    end

    // Count consecutive samples that disagree with the filtered level and
    // flip the level once the run is long enough; short pulses reset the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_r <= 1'b1;
            cnt_r   <= {CNT_W{1'b0}};
            fall_r  <= 1'b0;
        end else if (sync_r[1] != level_r) begin
            if (cnt_r == CNT_W'(FILTER_LEN - 1)) begin
                level_r <= sync_r[1];
                cnt_r   <= {CNT_W{1'b0}};
                fall_r  <= EDGE_EN & level_r;
            end else begin
                cnt_r   <= cnt_r + CNT_W'(1);
                fall_r  <= 1'b0;
            end
        end else begin
            cnt_r  <= {CNT_W{1'b0}};
            fall_r <= 1'b0;
        end
    end

    assign sync  = sync_r[1];
    assign level = level_r;
    assign fall  = fall_r;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: samples data on filtered falling edges of the
// keyboard clock, assembles 11-bit frames, reports good bytes or errors.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic       clk,
    input  logic       reset_n_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] code_o,
    output logic       strobe_o,
    output logic       err_o
);

    localparam int          TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]  STOP_CNT = 4'(STOP_POS);

    logic [1:0]           rst_pipe_r;
    logic                 rst_n_s;
    logic                 sample_s;
    logic                 data_sync_s;
    logic                 clk_sync_unused_s;
    logic                 clk_level_unused_s;
    logic                 data_level_unused_s;
    logic                 data_fall_unused_s;
    logic [FRAME_LEN-1:0] frame_shift_s;
    logic                 frame_ok_s;

    ps2_state_e           state_r;
    logic [3:0]           bit_cnt_r;
    logic [FRAME_LEN-1:0] frame_r;
    logic [TO_W-1:0]      to_cnt_r;
    logic [7:0]           code_r;
    logic                 strobe_r;
    logic                 err_r;

    // Assert reset immediately, release it synchronously so every flop
    // downstream leaves reset on the same edge.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rst_pipe_r <= 2'b00;
        end else begin
            rst_pipe_r <= {rst_pipe_r[0], 1'b1};
        end
    end

    assign rst_n_s = rst_pipe_r[1];

    ps2_filter #(.FILTER_LEN(FILTER_LEN), .EDGE_EN(1'b1)) u_clk_filt (
        .clk   (clk),
        .rst_n (rst_n_s),
        .raw   (ps2_clk_i),
        .sync  (clk_sync_unused_s),
        .level (clk_level_unused_s),
        .fall  (sample_s)
    );

    // Data is used straight from its synchronizer; its filter is not needed.
    ps2_filter #(.FILTER_LEN(FILTER_LEN), .EDGE_EN(1'b0)) u_data_filt (
        .clk   (clk),
        .rst_n (rst_n_s),
        .raw   (ps2_data_i),
        .sync  (data_sync_s),
        .level (data_level_unused_s),
        .fall  (data_fall_unused_s)
    );

    // New bits enter at the top so the start bit ends up at bit 0.
    assign frame_shift_s = {data_sync_s, frame_r[FRAME_LEN-1:1]};
    assign frame_ok_s    = frame_good(frame_shift_s);

    // Frame FSM; the verdict is taken on the stop-bit event itself so the
    // strobe/error pulse lands during the single CHECK cycle.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 4'd0;
            frame_r   <= {FRAME_LEN{1'b0}};
            to_cnt_r  <= {TO_W{1'b0}};
            code_r    <= 8'h00;
            strobe_r  <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            strobe_r <= 1'b0;
            err_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    to_cnt_r <= {TO_W{1'b0}};
                    if (sample_s && !data_sync_s) begin
                        state_r   <= ST_RECV;
                        bit_cnt_r <= 4'd1;
                        frame_r   <= frame_shift_s;
                    end else begin
                        bit_cnt_r <= 4'd0;
                    end
                end
                ST_RECV: begin
                    if (sample_s) begin
                        frame_r  <= frame_shift_s;
                        to_cnt_r <= {TO_W{1'b0}};
                        if (bit_cnt_r == STOP_CNT) begin
                            state_r   <= ST_CHECK;
                            bit_cnt_r <= 4'd0;
                            if (frame_ok_s) begin
                                strobe_r <= 1'b1;
                                code_r   <= frame_shift_s[DATA_MSB:DATA_LSB];
                            end else begin
                                err_r    <= 1'b1;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end else if (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        // Counter is about to reach TIMEOUT_CYCLES: abandon frame.
                        err_r     <= 1'b1;
                        state_r   <= ST_IDLE;
                        bit_cnt_r <= 4'd0;
                        to_cnt_r  <= {TO_W{1'b0}};
                        frame_r   <= {FRAME_LEN{1'b0}};
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_W'(1);
                    end
                end
                ST_CHECK: begin
                    state_r  <= ST_IDLE;
                    to_cnt_r <= {TO_W{1'b0}};
                end
                default: begin
                    state_r   <= ST_IDLE;
                    bit_cnt_r <= 4'd0;
                    to_cnt_r  <= {TO_W{1'b0}};
                end
            endcase
        end
    end

    assign code_o   = code_r;
    assign strobe_o = strobe_r;
    assign err_o    = err_r;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: 1 MHz system clock, 12.5 kHz PS/2 clock
// (40 cycles per half period), shortened timeout to keep runs small.
module tb_ps2_kbd_rx;

    localparam int FLEN = 8;
    localparam int TOUT = 400;
    localparam int HALF = 40;

    // Frames as bit10..bit0 = stop, parity, data[7:0], start (hand-built).
    localparam logic [10:0] F_1C        = 11'h438;  // 0x1C, parity 0
    localparam logic [10:0] F_1C_BADPAR = 11'h638;  // parity forced to 1
    localparam logic [10:0] F_1C_BADSTP = 11'h038;  // stop bit 0
    localparam logic [10:0] F_F0        = 11'h7E0;  // 0xF0, parity 1

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] code_o;
    logic       strobe_o;
    logic       err_o;

    int vec_cnt = 0;
    int miscmp_cnt = 0;
    int cyc = 0;
    int strobe_seen = 0;
    int err_seen = 0;
    int both_seen = 0;
    int last_err_cyc = 0;
    int last_fall_cyc = 0;
    int s0, e0;
    logic [7:0] code_q[$];

    ps2_kbd_rx #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk        (clk),
        .reset_n_i  (reset_n),
        .ps2_clk_i  (ps2_clk),
        .ps2_data_i (ps2_data),
        .code_o     (code_o),
        .strobe_o   (strobe_o),
        .err_o      (err_o)
    );

    always #500 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sample outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (strobe_o) begin
            strobe_seen++;
            code_q.push_back(code_o);
        end
        if (err_o) begin
            err_seen++;
            last_err_cyc = cyc;
        end
        if (strobe_o && err_o) both_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive nbits of a frame; glitch_at selects a bit whose high phase gets
    // a 3-cycle low glitch on the clock line.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_at);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            if (i == glitch_at) begin
                wait_cyc(10);
                ps2_clk = 1'b0;
                wait_cyc(3);
                ps2_clk = 1'b1;
                wait_cyc(HALF - 13);
            end else begin
                wait_cyc(HALF);
            end
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic snap();
        s0 = strobe_seen;
        e0 = err_seen;
        code_q.delete();
    endtask

    initial begin
        wait_cyc(5);
        chk("rst_code", code_o, 8'h00);
        chk("rst_strobe", strobe_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        reset_n = 1'b1;
        wait_cyc(5);

        // Parity error straight after reset: code stays at its reset value.
        snap();
        send_bits(F_1C_BADPAR, 11, -1);
        wait_cyc(20);
        chk("par_err", err_seen - e0, 1);
        chk("par_strobe", strobe_seen - s0, 0);
        chk("par_code", code_o, 8'h00);

        // Good 0x1C frame.
        snap();
        send_bits(F_1C, 11, -1);
        wait_cyc(20);
        chk("good_strobe", strobe_seen - s0, 1);
        chk("good_err", err_seen - e0, 0);
        chk("good_code_pulse", code_q[0], 8'h1C);
        chk("good_code_hold", code_o, 8'h1C);

        // Back-to-back frames.
        snap();
        send_bits(F_F0, 11, -1);
        send_bits(F_1C, 11, -1);
        wait_cyc(20);
        chk("b2b_strobe", strobe_seen - s0, 2);
        chk("b2b_err", err_seen - e0, 0);
        chk("b2b_code0", code_q[0], 8'hF0);
        chk("b2b_code1", code_q[1], 8'h1C);

        // Framing error (stop bit low).
        snap();
        send_bits(F_1C_BADSTP, 11, -1);
        wait_cyc(20);
        chk("stop_err", err_seen - e0, 1);
        chk("stop_strobe", strobe_seen - s0, 0);
        chk("stop_code", code_o, 8'h1C);

        // Timeout: start + 4 data bits, then the clock stays high. The sample
        // event trails the driven fall by 2 sync + FLEN filter + 1 cycles.
        snap();
        send_bits(F_1C, 5, -1);
        wait_cyc(TOUT + 100);
        chk("to_err", err_seen - e0, 1);
        chk("to_strobe", strobe_seen - s0, 0);
        chk("to_delay", last_err_cyc - last_fall_cyc, TOUT + FLEN + 3);
        snap();
        send_bits(F_1C, 11, -1);
        wait_cyc(20);
        chk("to_next_strobe", strobe_seen - s0, 1);
        chk("to_next_code", code_q[0], 8'h1C);

        // Glitches: idle (with data low, so a false start would show) and mid-frame.
        snap();
        ps2_data = 1'b0;
        wait_cyc(5);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(20);
        ps2_data = 1'b1;
        wait_cyc(20);
        send_bits(F_1C, 11, 4);
        wait_cyc(20);
        chk("glitch_strobe", strobe_seen - s0, 1);
        chk("glitch_err", err_seen - e0, 0);
        chk("glitch_code", code_q[0], 8'h1C);

        // Reset in the middle of a frame.
        snap();
        send_bits(F_1C, 6, -1);
        wait_cyc(2);
        reset_n = 1'b0;
        wait_cyc(3);
        chk("mrst_code", code_o, 8'h00);
        chk("mrst_strobe_o", strobe_o, 1'b0);
        chk("mrst_err_o", err_o, 1'b0);
        reset_n = 1'b1;
        wait_cyc(TOUT + 50);
        chk("mrst_no_strobe", strobe_seen - s0, 0);
        chk("mrst_no_err", err_seen - e0, 0);
        snap();
        send_bits(F_1C, 11, -1);
        wait_cyc(20);
        chk("mrst_next_strobe", strobe_seen - s0, 1);
        chk("mrst_next_code", code_o, 8'h1C);

        chk("never_both", both_seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
